stack_seq: RTL and testbench

//  Parametrised multi-cycle stack/flow sequencer. Executes the stack-class ops the core lacks:
//  PHA, PHP, PLA, PLP, JSR, RTS, BRK, RTI. Sits beside the core FSM: the core issues one START,
//  the block owns the memory port until DONE, then returns register/PC results with write strobes.

---
 rtl/stack_seq.sv | 191 +++++++++++++++++++
 tb/tb_stack_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_seq.sv
// Multi-cycle stack/flow sequencer for PHA, PHP, PLA, PLP, JSR, RTS, BRK and RTI.
// Define STACK_GUARD_EN to add the sticky stack-wrap error flag on err_o.
module stack_seq #(
  parameter int unsigned       DW       = 8,
  parameter logic [DW-1:0]     SP_PAGE  = 8'h01,
  parameter logic [DW-1:0]     SP_INIT  = 8'hFF,
  parameter logic [DW-1:0]     BRK_MASK = 8'h10,
  parameter logic [2*DW-1:0]   BRK_VEC  = 16'hFFFE
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [2:0]        cmd_i,
  input  logic [DW-1:0]     a_i,
  input  logic [DW-1:0]     p_i,
  input  logic [2*DW-1:0]   pc_i,
  input  logic [2*DW-1:0]   tgt_i,
  input  logic [DW-1:0]     mem_rdata_i,
  output logic [2*DW-1:0]   mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  output logic              mem_we_o,
  output logic [DW-1:0]     a_o,
  output logic              a_we_o,
  output logic [DW-1:0]     p_o,
  output logic              p_we_o,
  output logic [2*DW-1:0]   pc_o,
  output logic              pc_we_o,
  output logic [DW-1:0]     sp_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned AW = 2 * DW;

  localparam logic [3:0] StIdle = 4'd0,  StPshH = 4'd1,  StPshL = 4'd2,  StPshP = 4'd3;
  localparam logic [3:0] StPshA = 4'd4,  StPulP = 4'd5,  StPulL = 4'd6,  StPulH = 4'd7;
  localparam logic [3:0] StPulA = 4'd8,  StVecL = 4'd9,  StVecH = 4'd10, StFin  = 4'd11;

  localparam logic [2:0] CmdPha = 3'd0, CmdPhp = 3'd1, CmdPla = 3'd2, CmdPlp = 3'd3;
  localparam logic [2:0] CmdJsr = 3'd4, CmdRts = 3'd5, CmdBrk = 3'd6, CmdRti = 3'd7;

  logic [3:0]    state_q, state_d;
  logic [2:0]    cmd_q, cmd_d;
  logic [DW-1:0] sp_q, sp_d, a_q, a_d, p_q, p_d, lo_q, lo_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          is_push, is_pull;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    sp_d        = sp_q;
    a_d         = a_q;
    p_d         = p_q;
    lo_d        = lo_q;
    pc_d        = pc_q;
    is_push     = 1'b0;
    is_pull     = 1'b0;
    mem_addr_o  = {SP_PAGE, sp_q};
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          cmd_d = cmd_i;
          unique case (cmd_i)
            CmdPha:          state_d = StPshA;
            CmdPhp:          state_d = StPshP;
            CmdPla:          state_d = StPulA;
            CmdPlp, CmdRti:  state_d = StPulP;
            CmdJsr, CmdBrk:  state_d = StPshH;
            CmdRts:          state_d = StPulL;
          endcase
        end
      end
      StPshH: begin
        is_push     = 1'b1;
        mem_wdata_o = pc_i[AW-1:DW];
        state_d     = StPshL;
      end
      StPshL: begin
        is_push     = 1'b1;
        mem_wdata_o = pc_i[DW-1:0];
        if (cmd_q == CmdBrk) begin
          state_d = StPshP;
        end else begin
          pc_d    = tgt_i;
          state_d = StFin;
        end
      end
      StPshP: begin
        is_push     = 1'b1;
        mem_wdata_o = (cmd_q == CmdBrk) ? (p_i | BRK_MASK) : p_i;
        state_d     = (cmd_q == CmdBrk) ? StVecL : StFin;
      end
      StPshA: begin
        is_push     = 1'b1;
        mem_wdata_o = a_i;
        state_d     = StFin;
      end
      StPulP: begin
        is_pull = 1'b1;
        p_d     = mem_rdata_i;
        state_d = (cmd_q == CmdRti) ? StPulL : StFin;
      end
      StPulL: begin
        is_pull = 1'b1;
        lo_d    = mem_rdata_i;
        state_d = StPulH;
      end
      StPulH: begin
        is_pull = 1'b1;
        // RTS returns to the byte after the pushed address; RTI does not.
        pc_d    = {mem_rdata_i, lo_q} + ((cmd_q == CmdRts) ? AW'(1) : AW'(0));
        state_d = StFin;
      end
      StPulA: begin
        is_pull = 1'b1;
        a_d     = mem_rdata_i;
        state_d = StFin;
      end
      StVecL: begin
        mem_addr_o = BRK_VEC;
        lo_d       = mem_rdata_i;
        state_d    = StVecH;
      end
      StVecH: begin
        mem_addr_o = BRK_VEC + AW'(1);
        pc_d       = {mem_rdata_i, lo_q};
        state_d    = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (is_push) begin
      mem_we_o = 1'b1;
      sp_d     = sp_q - DW'(1);
    end
    if (is_pull) begin
      mem_addr_o = {SP_PAGE, sp_q + DW'(1)};
      sp_d       = sp_q + DW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cmd_q   <= CmdPha;
      sp_q    <= SP_INIT;
      a_q     <= '0;
      p_q     <= '0;
      lo_q    <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      sp_q    <= sp_d;
      a_q     <= a_d;
      p_q     <= p_d;
      lo_q    <= lo_d;
      pc_q    <= pc_d;
    end
  end

`ifdef STACK_GUARD_EN
  logic err_q, err_d;

  assign err_d = err_q | (is_push && (sp_q == '0)) | (is_pull && (sp_q == '1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign a_o     = a_q;
  assign p_o     = p_q;
  assign pc_o    = pc_q;
  assign sp_o    = sp_q;
  assign done_o  = (state_q == StFin);
  assign busy_o  = (state_q != StIdle);
  assign a_we_o  = done_o && (cmd_q == CmdPla);
  assign p_we_o  = done_o && ((cmd_q == CmdPlp) || (cmd_q == CmdRti));
  assign pc_we_o = done_o && ((cmd_q == CmdJsr) || (cmd_q == CmdRts) ||
                              (cmd_q == CmdBrk) || (cmd_q == CmdRti));

endmodule

// File: tb/tb_stack_seq.sv
// Scoreboard bench for stack_seq: a byte-level stack model predicts writes and completions.
module tb_stack_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [2:0]  cmd_i;
  logic [7:0]  a_i, p_i, mem_rdata_i, mem_wdata_o, a_o, p_o, sp_o;
  logic [15:0] pc_i, tgt_i, mem_addr_o, pc_o;
  logic        mem_we_o, a_we_o, p_we_o, pc_we_o, busy_o, done_o, err_o;

  stack_seq dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .cmd_i      (cmd_i),
    .a_i        (a_i),
    .p_i        (p_i),
    .pc_i       (pc_i),
    .tgt_i      (tgt_i),
    .mem_rdata_i(mem_rdata_i),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_we_o   (mem_we_o),
    .a_o        (a_o),
    .a_we_o     (a_we_o),
    .p_o        (p_o),
    .p_we_o     (p_we_o),
    .pc_o       (pc_o),
    .pc_we_o    (pc_we_o),
    .sp_o       (sp_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] mem [65536];
  assign mem_rdata_i = mem[mem_addr_o];
  always @(posedge clk_i) if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;

  typedef struct {
    logic [7:0]  a, p, sp;
    logic [15:0] pc;
    logic        awe, pwe, pcwe, err;
    int          lat;
  } exp_t;
  typedef struct {
    logic [15:0] addr;
    logic [7:0]  d;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  exp_t e_cur;
  wr_t  w_cur;

  logic [7:0]  m_mem [65536];
  logic [7:0]  m_sp, m_a, m_p;
  logic [15:0] m_pc;
  logic        m_err;
  int          cyc = 0;
  int          start_cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic mpush(input logic [7:0] d);
    wr_t w;
    w.addr = {8'h01, m_sp};
    w.d    = d;
    wr_q.push_back(w);
    m_mem[w.addr] = d;
`ifdef STACK_GUARD_EN
    if (m_sp == 8'h00) m_err = 1'b1;
`endif
    m_sp = m_sp - 8'd1;
  endtask

  task automatic mpull(output logic [7:0] d);
`ifdef STACK_GUARD_EN
    if (m_sp == 8'hFF) m_err = 1'b1;
`endif
    m_sp = m_sp + 8'd1;
    d = m_mem[{8'h01, m_sp}];
  endtask

  task automatic model_reset();
    m_sp = 8'hFF; m_a = 8'h00; m_p = 8'h00; m_pc = 16'h0000; m_err = 1'b0;
  endtask

  // Predict one command, then drive it and wait (bounded) for completion.
  task automatic issue(input logic [2:0] cmd, input logic [7:0] a, input logic [7:0] p,
                       input logic [15:0] pc, input logic [15:0] tgt, input bit hold);
    exp_t e;
    logic [7:0] lo, hi;
    int n;
    e.awe = 1'b0; e.pwe = 1'b0; e.pcwe = 1'b0;
    case (cmd)
      3'd0: begin mpush(a); e.lat = 2; end
      3'd1: begin mpush(p); e.lat = 2; end
      3'd2: begin mpull(m_a); e.awe = 1'b1; e.lat = 2; end
      3'd3: begin mpull(m_p); e.pwe = 1'b1; e.lat = 2; end
      3'd4: begin mpush(pc[15:8]); mpush(pc[7:0]); m_pc = tgt; e.pcwe = 1'b1; e.lat = 3; end
      3'd5: begin
        mpull(lo); mpull(hi); m_pc = {hi, lo} + 16'd1; e.pcwe = 1'b1; e.lat = 3;
      end
      3'd6: begin
        mpush(pc[15:8]); mpush(pc[7:0]); mpush(p | 8'h10);
        m_pc = {m_mem[16'hFFFF], m_mem[16'hFFFE]}; e.pcwe = 1'b1; e.lat = 6;
      end
      default: begin
        mpull(m_p); mpull(lo); mpull(hi); m_pc = {hi, lo};
        e.pwe = 1'b1; e.pcwe = 1'b1; e.lat = 4;
      end
    endcase
    e.a = m_a; e.p = m_p; e.pc = m_pc; e.sp = m_sp; e.err = m_err;
    exp_q.push_back(e);
    @(negedge clk_i);
    cmd_i = cmd; a_i = a; p_i = p; pc_i = pc; tgt_i = tgt; start_i = 1'b1;
    start_cyc = cyc;
    @(negedge clk_i);
    if (!hold) start_i = 1'b0;
    n = 0;
    while (!done_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!done_o) check("done_timeout", 32'd0, 32'd1);
    start_i = 1'b0;
    @(negedge clk_i);
    check("idle_after_done", {31'd0, busy_o}, 32'd0);
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (mem_we_o) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          w_cur = wr_q.pop_front();
          check("wr_addr", {16'd0, mem_addr_o}, {16'd0, w_cur.addr});
          check("wr_data", {24'd0, mem_wdata_o}, {24'd0, w_cur.d});
        end
      end
      if (done_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e_cur = exp_q.pop_front();
          check("latency", cyc - start_cyc, e_cur.lat);
          check("a_we", {31'd0, a_we_o}, {31'd0, e_cur.awe});
          check("p_we", {31'd0, p_we_o}, {31'd0, e_cur.pwe});
          check("pc_we", {31'd0, pc_we_o}, {31'd0, e_cur.pcwe});
          check("a_out", {24'd0, a_o}, {24'd0, e_cur.a});
          check("p_out", {24'd0, p_o}, {24'd0, e_cur.p});
          check("pc_out", {16'd0, pc_o}, {16'd0, e_cur.pc});
          check("sp", {24'd0, sp_o}, {24'd0, e_cur.sp});
          check("err", {31'd0, err_o}, {31'd0, e_cur.err});
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; cmd_i = 3'd0; a_i = 8'h00; p_i = 8'h00;
    pc_i = 16'h0000; tgt_i = 16'h0000;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      m_mem[i] = 8'h00;
    end
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'hF0;
    m_mem[16'hFFFE] = 8'h00; m_mem[16'hFFFF] = 8'hF0;
    model_reset();
    repeat (3) @(negedge clk_i);
    check("rst_sp", {24'd0, sp_o}, 32'hFF);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_we", {31'd0, mem_we_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_outs", {a_o, p_o, pc_o}, 32'd0);
    check("rst_addr", {16'd0, mem_addr_o}, 32'h01FF);
    rst_ni = 1'b1;

    issue(3'd0, 8'h5A, 8'h00, 16'h0000, 16'h0000, 1'b0);  // PHA
    issue(3'd2, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0);  // PLA
    issue(3'd4, 8'h00, 8'h00, 16'h1234, 16'h8000, 1'b0);  // JSR
    issue(3'd5, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0);  // RTS
    issue(3'd6, 8'h00, 8'h81, 16'hC0DE, 16'h0000, 1'b0);  // BRK
    issue(3'd7, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0);  // RTI
    issue(3'd1, 8'h00, 8'hA5, 16'h0000, 16'h0000, 1'b1);  // PHP, START held
    issue(3'd3, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b1);  // PLP, START held

    // Walk SP down to 00, then push across the wrap.
    for (int i = 0; i < 255; i++) issue(3'd0, i[7:0], 8'h00, 16'h0000, 16'h0000, 1'b0);
    check("sp_at_00", {24'd0, sp_o}, 32'h00);
    issue(3'd1, 8'h00, 8'h3C, 16'h0000, 16'h0000, 1'b0);

    // Reset in the middle of JSR, while its second push is on the bus.
    @(negedge clk_i);
    cmd_i = 3'd4; pc_i = 16'h1234; tgt_i = 16'h8000; start_i = 1'b1;
    mpush(8'h12);
    mpush(8'h34);
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("midrst_we", {31'd0, mem_we_o}, 32'd0);
    check("midrst_sp", {24'd0, sp_o}, 32'hFF);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_err", {31'd0, err_o}, 32'd0);
    check("midrst_wr_left", wr_q.size(), 32'd0);
    exp_q.delete();
    wr_q.delete();
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    issue(3'd0, 8'h77, 8'h00, 16'h0000, 16'h0000, 1'b0);
    check("final_mem", {24'd0, mem[16'h01FF]}, 32'h77);

    repeat (4) @(negedge clk_i);
    check("exp_left", exp_q.size(), 32'd0);
    check("wr_left", wr_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
